// File: rtl/dac_sequencer_pkg.sv
// Shared types and helpers for the DAC sequencer slice.
package dac_seq_pkg;

  // Controller state: waiting for a request, or holding a code while the DAC settles
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Default DAC code width
  localparam int DAC_DATA_W = 10;

  // Width of a counter that must hold values 0..settle_cycles
  function automatic int cnt_width(input int settle_cycles);
    return $clog2(settle_cycles + 1);
  endfunction

endpackage

// File: rtl/dac_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted channel and wraps, so the most recently served channel has lowest priority.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any_grant
);

  // Walk the channels in rotated order and take the first requester
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    if (enable) begin
      for (int off = 1; off <= NUM_CH; off++) begin
        idx = (int'(last_grant) + off) % NUM_CH;
        if (!any_grant && req[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = IDX_W'(idx);
          any_grant  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dac_sequencer.sv
// Time-multiplexes a single DAC between NUM_CH requesting channels.
// A round-robin winner's code is latched, strobed into the DAC with dac_load,
// and held for SETTLE_CYCLES before the next channel can be served.
// Optional feature: define DAC_CODE_CLAMP_EN to clamp latched codes into
// [CODE_MIN, CODE_MAX] and report clamping on clamp_hit.
module dac_sequencer
  import dac_seq_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DATA_W        = DAC_DATA_W,
  parameter int SETTLE_CYCLES = 8,
  parameter int CODE_MIN      = 0,
  parameter int CODE_MAX      = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH*DATA_W-1:0]   req_code,
  output logic [NUM_CH-1:0]          req_ready,
  output logic [DATA_W-1:0]          dac_code,
  output logic                       dac_load,
  output logic [$clog2(NUM_CH)-1:0]  mux_sel,
  output logic                       busy,
  output logic                       settled,
  output logic                       clamp_hit
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = cnt_width(SETTLE_CYCLES);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   last_grant;
  logic [NUM_CH-1:0]  grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_grant;
  logic               arb_enable;
  logic [DATA_W-1:0]  code_raw;
  logic [DATA_W-1:0]  code_latched;
  logic               code_clamped;

  // Requests are only offered while idle and never while reset is held
  assign arb_enable = (state == IDLE) && !rst;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arbiter (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     (arb_enable),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_grant  (any_grant)
  );

  assign req_ready = grant;
  assign code_raw  = req_code[grant_idx*DATA_W +: DATA_W];

`ifdef DAC_CODE_CLAMP_EN
  localparam logic [DATA_W-1:0] CODE_LO = DATA_W'(CODE_MIN);
  localparam logic [DATA_W-1:0] CODE_HI = DATA_W'(CODE_MAX);

  // Saturate the winning code into the allowed window and flag when it moved
  always_comb begin
    code_latched = code_raw;
    code_clamped = 1'b0;
    if (code_raw < CODE_LO) begin
      code_latched = CODE_LO;
      code_clamped = 1'b1;
    end else if (code_raw > CODE_HI) begin
      code_latched = CODE_HI;
      code_clamped = 1'b1;
    end
  end
`else
  logic unused_clamp_params;

  // Without clamping the raw code goes straight through and the limits are unused
  assign code_latched        = code_raw;
  assign code_clamped        = 1'b0;
  assign unused_clamp_params = (CODE_MIN > CODE_MAX);
`endif

  // Busy and settled are decoded from the hold window
  assign busy    = (state == HOLD);
  assign settled = (state == HOLD) && (cnt == CNT_W'(1));

  // Sequencer FSM: accept one request, load it, then hold for the settle window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= IDX_W'(NUM_CH - 1);
      dac_code   <= '0;
      mux_sel    <= '0;
      dac_load   <= 1'b0;
      clamp_hit  <= 1'b0;
    end else begin
      dac_load  <= 1'b0;
      clamp_hit <= 1'b0;
      case (state)
        IDLE: begin
          if (any_grant) begin
            dac_code   <= code_latched;
            mux_sel    <= grant_idx;
            last_grant <= grant_idx;
            dac_load   <= 1'b1;
            clamp_hit  <= code_clamped;
            cnt        <= CNT_W'(SETTLE_CYCLES);
            state      <= HOLD;
          end
        end
        HOLD: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sequencer.sv
// Self-checking bench for dac_sequencer (NUM_CH=4, SETTLE_CYCLES=8, limits 16..1000).
// Expected loads are queued when a request is driven and checked when dac_load appears.
module tb_dac_sequencer;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 10;
  localparam int SETTLE = 8;
  localparam int CMIN   = 16;
  localparam int CMAX   = 1000;
`ifdef DAC_CODE_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] code;
    logic [1:0]        ch;
    logic              clamp;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        req_valid = '0;
  logic [NUM_CH*DATA_W-1:0] req_code = '0;
  logic [NUM_CH-1:0]        req_ready;
  logic [DATA_W-1:0]        dac_code;
  logic                     dac_load;
  logic [1:0]               mux_sel;
  logic                     busy;
  logic                     settled;
  logic                     clamp_hit;

  exp_t sb[$];
  exp_t e;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;

  logic [DATA_W-1:0] rr_codes [4] = '{10'h010, 10'h020, 10'h030, 10'h040};
  int                cl_ch    [4] = '{1, 2, 3, 0};
  logic [DATA_W-1:0] cl_raw   [4] = '{10'd1023, 10'd5, 10'd1000, 10'd16};
  logic [DATA_W-1:0] cl_exp   [4];
  logic              cl_hit   [4];

  dac_sequencer #(
    .NUM_CH        (NUM_CH),
    .DATA_W        (DATA_W),
    .SETTLE_CYCLES (SETTLE),
    .CODE_MIN      (CMIN),
    .CODE_MAX      (CMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .dac_code  (dac_code),
    .dac_load  (dac_load),
    .mux_sel   (mux_sel),
    .busy      (busy),
    .settled   (settled),
    .clamp_hit (clamp_hit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_code(input int ch, input logic [DATA_W-1:0] code);
    req_code[ch*DATA_W +: DATA_W] = code;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NUM_CH; i++) set_code(i, rr_codes[i]);
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready); end
    tests_run++;
    if (dac_code !== '0) begin tests_failed++; $display("[TB] FAIL reset_code: got %h expected 000", dac_code); end
    tests_run++;
    if (mux_sel !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_mux: got %0d expected 0", mux_sel); end
    tests_run++;
    if ({busy, dac_load, settled, clamp_hit} !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL reset_flags: got busy/load/settled/clamp %b expected 0000", {busy, dac_load, settled, clamp_hit});
    end
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_code(2, 10'h155);
    req_valid = 4'b0100;
    sb.push_back(exp_t'{code: 10'h155, ch: 2'd2, clamp: 1'b0});
    @(negedge clk);
    tests_run++;
    if (req_ready !== 4'b0100) begin tests_failed++; $display("[TB] FAIL single_ready: got %b expected 0100", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    e = sb.pop_front();
    tests_run++;
    if ({dac_load, dac_code, mux_sel, clamp_hit} !== {1'b1, e.code, e.ch, e.clamp}) begin
      tests_failed++;
      $display("[TB] FAIL single_load: got load=%b code=%h ch=%0d clamp=%b expected load=1 code=%h ch=%0d clamp=%b",
               dac_load, dac_code, mux_sel, clamp_hit, e.code, e.ch, e.clamp);
    end
    for (int k = 1; k <= SETTLE; k++) begin
      tests_run++;
      if ({busy, settled, dac_load} !== {1'b1, k == SETTLE, k == 1}) begin
        tests_failed++;
        $display("[TB] FAIL single_hold_%0d: got busy/settled/load %b expected %b", k, {busy, settled, dac_load}, {1'b1, k == SETTLE, k == 1});
      end
      @(negedge clk);
    end
    req_valid = 4'b0100;
    #1;
    tests_run++;
    if ({busy, req_ready} !== {1'b0, 4'b0100}) begin
      tests_failed++; $display("[TB] FAIL single_next_accept: got busy=%b ready=%b expected busy=0 ready=0100", busy, req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int xfers = 0;
    int loads = 0;
    int last_xfer = -100;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_CH; i++) set_code(i, rr_codes[i]);
    req_valid = 4'b1111;
    for (int i = 0; i < 80 && loads < 5; i++) begin
      @(negedge clk);
      if (dac_load) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++; $display("[TB] FAIL rr_load_%0d: got unexpected load code=%h expected no load", loads, dac_code);
        end else begin
          e = sb.pop_front();
          if ({dac_code, mux_sel, clamp_hit} !== {e.code, e.ch, e.clamp} || cyc != last_xfer + 1) begin
            tests_failed++;
            $display("[TB] FAIL rr_load_%0d: got code=%h ch=%0d clamp=%b lat=%0d expected code=%h ch=%0d clamp=%b lat=1",
                     loads, dac_code, mux_sel, clamp_hit, cyc - last_xfer, e.code, e.ch, e.clamp);
          end
        end
        loads++;
      end
      if (req_ready !== 4'b0000 && xfers < 5) begin
        tests_run++;
        if (req_ready !== 4'(1 << (xfers % 4)) || (xfers > 0 && cyc - last_xfer != SETTLE + 1)) begin
          tests_failed++;
          $display("[TB] FAIL rr_grant_%0d: got ready=%b gap=%0d expected ready=%b gap=%0d",
                   xfers, req_ready, cyc - last_xfer, 4'(1 << (xfers % 4)), SETTLE + 1);
        end
        sb.push_back(exp_t'{code: rr_codes[xfers % 4], ch: 2'(xfers % 4), clamp: 1'b0});
        last_xfer = cyc;
        xfers++;
      end
    end
    req_valid = '0;
    tests_run++;
    if (loads != 5) begin tests_failed++; $display("[TB] FAIL rr_timeout: got %0d loads expected 5", loads); end
    sb.delete();
    repeat (SETTLE) tick();
  endtask

  task automatic test_hold_request();
    int t0;
    set_code(1, 10'h111);
    req_valid = 4'b0010;
    sb.push_back(exp_t'{code: 10'h111, ch: 2'd1, clamp: 1'b0});
    @(negedge clk);
    t0 = cyc;
    tests_run++;
    if (req_ready !== 4'b0010) begin tests_failed++; $display("[TB] FAIL hold_ch1_ready: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    e = sb.pop_front();
    tests_run++;
    if ({dac_load, dac_code, mux_sel} !== {1'b1, e.code, e.ch}) begin
      tests_failed++; $display("[TB] FAIL hold_ch1_load: got load=%b code=%h ch=%0d expected load=1 code=%h ch=%0d", dac_load, dac_code, mux_sel, e.code, e.ch);
    end
    tick();
    tick();
    set_code(3, 10'h3AB);
    req_valid = 4'b1000;
    sb.push_back(exp_t'{code: 10'h3AB, ch: 2'd3, clamp: 1'b0});
    for (int k = 3; k <= SETTLE; k++) begin
      @(negedge clk);
      tests_run++;
      if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL hold_block_%0d: got ready=%b expected 0000", k, req_ready); end
      tick();
    end
    @(negedge clk);
    tests_run++;
    if (req_ready !== 4'b1000 || cyc - t0 != SETTLE + 1) begin
      tests_failed++; $display("[TB] FAIL hold_ch3_accept: got ready=%b at T+%0d expected 1000 at T+%0d", req_ready, cyc - t0, SETTLE + 1);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    e = sb.pop_front();
    tests_run++;
    if ({dac_load, dac_code, mux_sel} !== {1'b1, e.code, e.ch}) begin
      tests_failed++; $display("[TB] FAIL hold_ch3_load: got load=%b code=%h ch=%0d expected load=1 code=%h ch=%0d", dac_load, dac_code, mux_sel, e.code, e.ch);
    end
    repeat (SETTLE) tick();
  endtask

  task automatic test_reset_mid_hold();
    set_code(2, 10'h2AA);
    req_valid = 4'b0100;
    sb.push_back(exp_t'{code: 10'h2AA, ch: 2'd2, clamp: 1'b0});
    @(negedge clk);
    tests_run++;
    if (req_ready !== 4'b0100) begin tests_failed++; $display("[TB] FAIL midrst_ready: got %b expected 0100", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    e = sb.pop_front();
    tests_run++;
    if ({dac_load, dac_code, mux_sel} !== {1'b1, e.code, e.ch}) begin
      tests_failed++; $display("[TB] FAIL midrst_load: got load=%b code=%h ch=%0d expected load=1 code=%h ch=%0d", dac_load, dac_code, mux_sel, e.code, e.ch);
    end
    repeat (4) tick();
    for (int i = 0; i < NUM_CH; i++) set_code(i, rr_codes[i]);
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, dac_code, mux_sel, dac_load, settled, req_ready} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_async: got busy=%b code=%h ch=%0d load=%b settled=%b ready=%b expected all 0",
               busy, dac_code, mux_sel, dac_load, settled, req_ready);
    end
    tick();
    rst = 1'b0;
    sb.push_back(exp_t'{code: rr_codes[0], ch: 2'd0, clamp: 1'b0});
    @(negedge clk);
    tests_run++;
    if (req_ready !== 4'b0001) begin tests_failed++; $display("[TB] FAIL midrst_first_win: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    e = sb.pop_front();
    tests_run++;
    if ({dac_load, dac_code, mux_sel} !== {1'b1, e.code, e.ch}) begin
      tests_failed++; $display("[TB] FAIL midrst_reload: got load=%b code=%h ch=%0d expected load=1 code=%h ch=%0d", dac_load, dac_code, mux_sel, e.code, e.ch);
    end
    repeat (SETTLE) tick();
  endtask

  task automatic test_clamp();
    cl_exp = CLAMP_ON ? '{10'd1000, 10'd16, 10'd1000, 10'd16} : '{10'd1023, 10'd5, 10'd1000, 10'd16};
    cl_hit = CLAMP_ON ? '{1'b1, 1'b1, 1'b0, 1'b0} : '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int n = 0; n < 4; n++) begin
      set_code(cl_ch[n], cl_raw[n]);
      req_valid = 4'(1 << cl_ch[n]);
      sb.push_back(exp_t'{code: cl_exp[n], ch: 2'(cl_ch[n]), clamp: cl_hit[n]});
      @(negedge clk);
      tests_run++;
      if (req_ready !== 4'(1 << cl_ch[n])) begin
        tests_failed++; $display("[TB] FAIL clamp_ready_%0d: got %b expected %b", n, req_ready, 4'(1 << cl_ch[n]));
      end
      tick();
      req_valid = '0;
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if ({dac_load, dac_code, mux_sel, clamp_hit} !== {1'b1, e.code, e.ch, e.clamp}) begin
        tests_failed++;
        $display("[TB] FAIL clamp_load_%0d: got load=%b code=%0d ch=%0d clamp=%b expected load=1 code=%0d ch=%0d clamp=%b",
                 n, dac_load, dac_code, mux_sel, clamp_hit, e.code, e.ch, e.clamp);
      end
      @(negedge clk);
      tests_run++;
      if (clamp_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL clamp_pulse_%0d: got clamp_hit=%b expected 0", n, clamp_hit); end
      repeat (SETTLE - 1) tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold_request();
    test_reset_mid_hold();
    test_clamp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
